// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM encoding, the slice width and a counter-width helper.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add4_slice.sv
// Purpose: combinational 4-bit ripple add exposing the carry into bit 3.
// Latency: zero cycles, pure combinational.
// Backpressure: none, no handshake.
module add4_slice (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] s4,
    output logic       co,
    output logic       c3
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s4   = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s4[i]  = a4[i] ^ b4[i] ^ c[i];
            c[i+1] = (a4[i] & b4[i]) | (a4[i] & c[i]) | (b4[i] & c[i]);
        end
    end

    assign co = c[4];
    assign c3 = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// Purpose: WIDTH-bit adder, one nibble per step LSB first; NSA_SETTLE_WAIT_EN adds per-nibble settle wait.
// Latency: start edge to done edge is NIB cycles, or NIB*(SETTLE_CYCLES+1) with NSA_SETTLE_WAIT_EN.
// Backpressure: none; start is ignored while busy, result held until the next accepted start.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             overflow
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = cnt_width(NIB);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W || SETTLE_CYCLES < 0) begin : g_bad_param
        $error("nibble_serial_adder: bad WIDTH or SETTLE_CYCLES");
    end

    state_t                    state;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic [WIDTH-1:0]          res;
    logic                      carry;
    logic [CNT_W-1:0]          cnt;
    logic [NIBBLE_W-1:0]       sum4;
    logic                      slice_co;
    logic                      slice_c3;
    logic                      step_en;
    logic [WIDTH+NIBBLE_W-1:0] res_cat;
    logic [WIDTH-1:0]          res_next;

    add4_slice u_slice (
        .a4 (a_sh[NIBBLE_W-1:0]),
        .b4 (b_sh[NIBBLE_W-1:0]),
        .ci (carry),
        .s4 (sum4),
        .co (slice_co),
        .c3 (slice_c3)
    );

    // New sum nibble enters at the top so the LSB nibble ends up at bit 0.
    assign res_cat  = {sum4, res};
    assign res_next = res_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];

`ifdef NSA_SETTLE_WAIT_EN
    localparam int WAIT_W = cnt_width(SETTLE_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYCLES);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ADD || step_en) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign step_en = (wait_cnt == WAIT_LAST);
`else
    assign step_en = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            s        <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    if (step_en) begin
                        a_sh  <= a_sh >> NIBBLE_W;
                        b_sh  <= b_sh >> NIBBLE_W;
                        carry <= slice_co;
                        res   <= res_next;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_NIB) begin
                            s        <= res_next;
                            c_out    <= slice_co;
                            overflow <= slice_c3 ^ slice_co;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16; step count follows NSA_SETTLE_WAIT_EN.
module tb_nibble_serial_adder;

`ifdef NSA_SETTLE_WAIT_EN
    localparam int STEPS = 16;
`else
    localparam int STEPS = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        c_out;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    nibble_serial_adder #(.WIDTH(16), .SETTLE_CYCLES(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .s        (s),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic [15:0] es, input logic eco, input logic eov);
        a = av; b = bv; c_in = ci; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_e0"}, 32'(busy), 32'd1);
        check({tag, "_done_e0"}, 32'(done), 32'd0);
        repeat (STEPS - 1) tick();
        check({tag, "_busy_last"}, 32'(busy), 32'd1);
        check({tag, "_done_early"}, 32'(done), 32'd0);
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_s"}, 32'(s), 32'(es));
        check({tag, "_cout"}, 32'(c_out), 32'(eco));
        check({tag, "_ovf"}, 32'(overflow), 32'(eov));
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_cout", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("wrap_b", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("wrap_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // start and operand changes mid-ADD must be ignored
        a = 16'h0F0F; b = 16'h0101; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_s_held", 32'(s), 32'h0000);
        tick();
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
        tick();
        start = 1'b0;
        repeat (STEPS - 3) tick();
        check("ign_done_early", 32'(done), 32'd0);
        tick();
        check("ign_done", 32'(done), 32'd1);
        check("ign_s", 32'(s), 32'h1010);
        check("ign_cout", 32'(c_out), 32'd0);
        tick();
        check("ign_idle_busy", 32'(busy), 32'd0);
        check("ign_idle_done", 32'(done), 32'd0);

        // reset at E2 discards the operation in flight and the held result
        a = 16'h1111; b = 16'h1111; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_s", 32'(s), 32'd0);
        check("mrst_state", 32'(dut.state), 32'd0);
        for (int i = 0; i < STEPS + 1; i++) begin
            tick();
            check("mrst_no_done", 32'(done), 32'd0);
        end
        run_op("after_rst", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

        // start held high through DONE: second op accepted back-to-back
        a = 16'h1234; b = 16'h4321; c_in = 1'b0; start = 1'b1;
        tick();
        a = 16'h0001; b = 16'h0002;
        repeat (STEPS - 1) tick();
        tick();
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_s1", 32'(s), 32'h5555);
        tick();
        start = 1'b0;
        check("b2b_busy2", 32'(busy), 32'd1);
        check("b2b_done_off", 32'(done), 32'd0);
        check("b2b_s_held", 32'(s), 32'h5555);
        repeat (STEPS - 1) tick();
        check("b2b_done2_early", 32'(done), 32'd0);
        tick();
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_s2", 32'(s), 32'h0003);
        check("b2b_cout2", 32'(c_out), 32'd0);
        tick();
        check("b2b_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequential WIDTH-bit adder that adds one 4-bit nibble per step through a shared 4-bit ripple slice, LSB nibble first, with a registered carry between steps.
- Sits directly upstream of result consumers and wraps the team's 4-bit ripple adder stage with a start/busy/done handshake.
- Replaces delay-based "ready" timing with clocked completion signalling.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4; NIB = WIDTH/4.
- SETTLE_CYCLES, 3, extra wait cycles per nibble; only used when NSA_SETTLE_WAIT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- c_in  input  1  carry in; captured on an accepted start.
- busy  output  1  high while in ADD.
- done  output  1  one-cycle pulse in DONE.
- s  output  WIDTH  sum; valid from done and held until the next accepted start.
- c_out  output  1  carry out of the MSB.
- overflow  output  1  signed overflow = carry into MSB XOR c_out.

Behaviour:
- Reset: state=IDLE; busy, done, s, c_out, overflow, the nibble counter and the carry register all clear to 0. Reset has priority over every other event, including mid-ADD; an operation in flight is discarded.
- IDLE:
  - start=1 → latch a, b and c_in into the operand shift registers and the carry register; counter=0; go to ADD.
  - s, c_out and overflow are not cleared on start. They hold the previous result until overwritten at the final nibble.
- ADD: busy=1. Each step:
  - Slice adds the low nibbles of the A/B shift registers plus the carry register.
  - Sum nibble shifts into the result register from the top; A/B shift right by 4.
  - Carry register takes the slice carry out; counter increments.
  - On step NIB-1: s is written with the full result, c_out=slice carry out, overflow=slice carry into bit 3 XOR slice carry out. Go to DONE.
- DONE: done=1, busy=0, for exactly one cycle.
  - start=1 → accepted as in IDLE (back-to-back); go to ADD.
  - Otherwise go to IDLE.
- start in ADD is ignored; captured operands are unaffected. Operand changes after capture have no effect.
- Latency without the macro: start sampled at edge E0 → busy high from E0 to E_NIB, done high from E_NIB to E_NIB+1. For WIDTH=16, done is high in the 5th cycle after start.
- Arithmetic is modulo 2^WIDTH; the carry out of the top nibble goes only to c_out.
- Counter width is clog2(NIB), minimum 1; it wraps to 0 on entry to ADD.

Optional Feature:
- NSA_SETTLE_WAIT_EN defined:
  - Each nibble step holds for SETTLE_CYCLES extra cycles before committing, using a wait counter that reloads per nibble.
  - busy stays high throughout; ADD latency = NIB*(SETTLE_CYCLES+1) cycles. This models the slice settling time.
  - Reset clears the wait counter.
- Undefined: one nibble per cycle; SETTLE_CYCLES is ignored and no wait counter is built.

Decomposition:
- Shared package nsa_pkg holds:
  - the state enum (IDLE=2'd0, ADD=2'd1, DONE=2'd2);
  - the NIBBLE_W=4 constant;
  - a clog2-based counter width function.
- One sub-module, add4_slice: purely combinational 4-bit ripple add with ports a4, b4, ci, s4, co, c3 (carry into bit 3). It has no delays and no ready signal.

Test Plan:
- WIDTH=16: a=0x1234, b=0x4321, c_in=0, start one cycle → done pulses once at E4, s=0x5555, c_out=0, overflow=0, busy high E0–E4.
- a=0xFFFF, b=0x0001, c_in=0 → s=0x0000, c_out=1, overflow=0. Repeat with a=0xFFFF, b=0x0000, c_in=1 → same result.
- a=0x7FFF, b=0x0001 → s=0x8000, c_out=0, overflow=1. Then a=0x8000, b=0x8000 → s=0x0000, c_out=1, overflow=1.
- Assert start at E2 of an operation with a=0x0F0F, b=0x0101, changing a/b at the same time → ignored; result 0x1010 and done still at E4.
- Assert rst at E2 of an operation → the next cycle shows busy=0, done=0, s=0, state IDLE. A fresh start then completes correctly.
- Hold start high through DONE with new operands 0x0001+0x0002 → second op accepted at the DONE edge, s=0x0003 after 4 more steps. With NSA_SETTLE_WAIT_EN defined and SETTLE_CYCLES=3, first done arrives at E16.
